// File: rtl/uart_mem_loader.sv
// rtl/uart_mem_loader.sv - byte-stream frame loader that writes words to SRAM and verifies them by readback
module uart_mem_loader #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  csb,
    output logic                  web,
    output logic [NUM_WMASKS-1:0] wmask,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] din,
    input  logic [DATA_WIDTH-1:0] dout,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    typedef enum logic [2:0] {HDR, DATA, CSUM, RD, RDWAIT, FIN} state_t;

    state_t                state_q, state_d;
    logic [1:0]            bidx_q, bidx_d;
    logic [15:0]           hdr_addr_q, hdr_addr_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [15:0]           word_q, word_d;
    logic [7:0]            sum_q, sum_d;
    logic [7:0]            csum_q, csum_d;
    logic [7:0]            rb_sum_q, rb_sum_d;
    logic                  csb_q, csb_d;
    logic                  web_q, web_d;
    logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [7:0]            rb_next;
    logic                  last_word;
    logic                  match;

    always_comb begin
        state_d    = state_q;
        bidx_d     = bidx_q;
        hdr_addr_d = hdr_addr_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        sum_d      = sum_q;
        csum_d     = csum_q;
        rb_sum_d   = rb_sum_q;
        addr_d     = addr_q;
        din_d      = din_q;
        csb_d      = 1'b1;
        web_d      = 1'b1;
        wmask_d    = '0;
        done_d     = 1'b0;
        error_d    = 1'b0;
        rb_next    = rb_sum_q + dout[7:0] + dout[15:8] + dout[23:16] + dout[31:24];
        last_word  = ({1'b0, word_q} + 17'd1) == {1'b0, cnt_q};
        match      = 1'b0;

        // The address advances the cycle after each write strobe, independent of byte capture.
        if (!csb_q && !web_q) begin
            addr_d = addr_q + 1'b1;
        end

        case (state_q)
            HDR: begin
                if (rx_valid) begin
                    bidx_d = bidx_q + 1'b1;
                    case (bidx_q)
                        2'd0: hdr_addr_d[7:0]  = rx_data;
                        2'd1: hdr_addr_d[15:8] = rx_data;
                        2'd2: cnt_d[7:0]       = rx_data;
                        default: begin
                            cnt_d[15:8] = rx_data;
                            addr_d      = hdr_addr_q[ADDR_WIDTH-1:0];
                            word_d      = '0;
                            state_d     = ({rx_data, cnt_q[7:0]} == 16'd0) ? CSUM : DATA;
                        end
                    endcase
                end
            end
            DATA: begin
                if (rx_valid) begin
                    din_d[{bidx_q, 3'b000} +: 8] = rx_data;
                    sum_d  = sum_q + rx_data;
                    bidx_d = bidx_q + 1'b1;
                    if (bidx_q == 2'd3) begin
                        csb_d   = 1'b0;
                        web_d   = 1'b0;
                        wmask_d = '1;
                        word_d  = word_q + 16'd1;
                        if (last_word) begin
                            state_d = CSUM;
                        end
                    end
                end
            end
            CSUM: begin
                if (rx_valid) begin
                    csum_d = rx_data;
                    if (cnt_q == 16'd0) begin
                        match   = (sum_q == rx_data) && (rx_data == rb_sum_q);
                        done_d  = match;
                        error_d = !match;
                        state_d = FIN;
                    end else begin
                        csb_d   = 1'b0;
                        addr_d  = hdr_addr_q[ADDR_WIDTH-1:0];
                        word_d  = '0;
                        state_d = RD;
                    end
                end
            end
            RD: begin
                state_d = RDWAIT;
            end
            RDWAIT: begin
                rb_sum_d = rb_next;
                word_d   = word_q + 16'd1;
                if (last_word) begin
                    match   = (sum_q == csum_q) && (csum_q == rb_next);
                    done_d  = match;
                    error_d = !match;
                    state_d = FIN;
                end else begin
                    csb_d   = 1'b0;
                    addr_d  = addr_q + 1'b1;
                    state_d = RD;
                end
            end
            default: begin
                bidx_d   = '0;
                sum_d    = '0;
                rb_sum_d = '0;
                state_d  = HDR;
            end
        endcase

        busy_d = (state_d != HDR) || (bidx_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HDR;
            bidx_q     <= '0;
            hdr_addr_q <= '0;
            cnt_q      <= '0;
            word_q     <= '0;
            sum_q      <= '0;
            csum_q     <= '0;
            rb_sum_q   <= '0;
            csb_q      <= 1'b1;
            web_q      <= 1'b1;
            wmask_q    <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bidx_q     <= bidx_d;
            hdr_addr_q <= hdr_addr_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            sum_q      <= sum_d;
            csum_q     <= csum_d;
            rb_sum_q   <= rb_sum_d;
            csb_q      <= csb_d;
            web_q      <= web_d;
            wmask_q    <= wmask_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign csb   = csb_q;
    assign web   = web_q;
    assign wmask = wmask_q;
    assign addr  = addr_q;
    assign din   = din_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;
endmodule

// File: tb/tb_uart_mem_loader.sv
// tb/tb_uart_mem_loader.sv - self-checking bench for uart_mem_loader
module tb_uart_mem_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        csb, web;
    logic [3:0]  wmask;
    logic [12:0] addr;
    logic [31:0] din;
    logic [31:0] dout = 32'h0;
    logic        busy, done, error;

    uart_mem_loader dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .csb(csb), .web(web), .wmask(wmask), .addr(addr), .din(din),
        .dout(dout), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:8191];
    logic        corrupt_en = 1'b0;
    logic [12:0] corrupt_addr = 13'h0;

    always @(posedge clk) begin
        if (!csb) begin
            if (!web) mem[addr] <= din;
            else dout <= mem[addr] ^ ((corrupt_en && addr == corrupt_addr) ? 32'h0000_0100 : 32'h0);
        end
    end

    logic [12:0] wa_log[$];
    logic [31:0] wd_log[$];
    logic [12:0] ra_log[$];
    int done_cnt = 0, err_cnt = 0, acc_cnt = 0, idle_bad = 0, wmask_bad = 0;

    always @(negedge clk) begin
        if (!csb) acc_cnt++;
        if (!csb && !web) begin
            wa_log.push_back(addr);
            wd_log.push_back(din);
            if (wmask != 4'hF) wmask_bad++;
        end
        if (!csb && web) ra_log.push_back(addr);
        if (csb && (!web || wmask != 4'h0)) idle_bad++;
        if (done) done_cnt++;
        if (error) err_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic gap(input bit b2b);
        int n;
        n = b2b ? 0 : $urandom_range(0, 2);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    logic [31:0] tx_words[$];

    task automatic run_frame(input logic [15:0] a, input logic [15:0] c, input logic [7:0] cs,
                             input bit b2b, input bit stray, input bit corr, input bit exp_done,
                             input string tag);
        bit ok_w, ok_r;
        int start;
        wa_log.delete(); wd_log.delete(); ra_log.delete();
        done_cnt = 0; err_cnt = 0;
        start = int'(a) % 8192;
        corrupt_en   = corr;
        corrupt_addr = 13'(start);
        drive_byte(a[7:0]);  gap(b2b);
        drive_byte(a[15:8]); gap(b2b);
        drive_byte(c[7:0]);  gap(b2b);
        drive_byte(c[15:8]); gap(b2b);
        for (int i = 0; i < int'(c); i++) begin
            for (int k = 0; k < 4; k++) begin
                drive_byte(tx_words[i][8*k +: 8]);
                gap(b2b);
            end
        end
        drive_byte(cs);
        if (stray) drive_byte(8'hA5);
        for (int t = 0; t < 2 * int'(c) + 20; t++) begin
            if (done_cnt + err_cnt > 0) break;
            @(posedge clk); #1;
        end
        repeat (3) begin @(posedge clk); #1; end
        ok_w = (wa_log.size() == int'(c)) && (wd_log.size() == int'(c));
        ok_r = (ra_log.size() == int'(c));
        for (int i = 0; i < int'(c); i++) begin
            if (ok_w && (int'(wa_log[i]) != (start + i) % 8192 || wd_log[i] != tx_words[i])) ok_w = 1'b0;
            if (ok_r && int'(ra_log[i]) != (start + i) % 8192) ok_r = 1'b0;
        end
        check({tag, " writes"}, 64'(ok_w), 64'd1);
        check({tag, " reads"},  64'(ok_r), 64'd1);
        check({tag, " done"},   64'(done_cnt), 64'(exp_done));
        check({tag, " error"},  64'(err_cnt),  64'(!exp_done));
        corrupt_en = 1'b0;
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [15:0] cnt;
        logic [31:0] w0, w1;
        logic [7:0]  csum;
        bit          b2b, stray, corrupt, exp_done;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int acc_snap;
        tbl[0] = '{16'h0010, 16'd2, 32'h44332211, 32'h88776655, 8'h64, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{16'h0010, 16'd2, 32'h44332211, 32'h88776655, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{16'h1FFF, 16'd2, 32'hDEADBEEF, 32'h01234567, 8'h08, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{16'h0000, 16'd0, 32'h0,        32'h0,        8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{16'h0000, 16'd0, 32'h0,        32'h0,        8'h01, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{16'h0010, 16'd2, 32'h44332211, 32'h88776655, 8'h64, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{16'hABCD, 16'd1, 32'h000000FF, 32'h0,        8'hFF, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{16'h0010, 16'd2, 32'h44332211, 32'h88776655, 8'h64, 1'b1, 1'b0, 1'b0, 1'b1};

        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h0;
        repeat (3) begin @(posedge clk); #1; end
        check("rst csb", 64'(csb), 64'd1);
        check("rst web", 64'(web), 64'd1);
        check("rst wmask", 64'(wmask), 64'd0);
        check("rst addr", 64'(addr), 64'd0);
        check("rst din", 64'(din), 64'd0);
        check("rst busy/done/error", 64'({busy, done, error}), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // cnt=0 frame: busy from first byte, done one cycle after checksum
        acc_snap = acc_cnt;
        check("busy idle", 64'(busy), 64'd0);
        drive_byte(8'h34);
        check("busy after hdr0", 64'(busy), 64'd1);
        drive_byte(8'h12); drive_byte(8'h00); drive_byte(8'h00);
        drive_byte(8'h00);
        check("cnt0 done timing", 64'({done, error, busy}), 64'b101);
        @(posedge clk); #1;
        check("cnt0 after fin", 64'({done, busy}), 64'd0);
        check("cnt0 no access", 64'(acc_cnt - acc_snap), 64'd0);

        for (int i = 0; i < 8; i++) begin
            tx_words.delete();
            tx_words.push_back(tbl[i].w0);
            tx_words.push_back(tbl[i].w1);
            run_frame(tbl[i].addr, tbl[i].cnt, tbl[i].csum, tbl[i].b2b, tbl[i].stray,
                      tbl[i].corrupt, tbl[i].exp_done, $sformatf("vec%0d", i));
        end

        // abandon a frame mid-data with reset
        drive_byte(8'h00); drive_byte(8'h01); drive_byte(8'h04); drive_byte(8'h00);
        for (int k = 0; k < 6; k++) drive_byte(8'(k + 1));
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check("midrst outputs", 64'({csb, web, busy, addr}), 64'({1'b1, 1'b1, 1'b0, 13'h0}));
        reset = 1'b0;
        acc_snap = acc_cnt;
        repeat (10) begin @(posedge clk); #1; end
        check("midrst no access", 64'(acc_cnt - acc_snap), 64'd0);
        tx_words.delete();
        tx_words.push_back(32'h44332211);
        tx_words.push_back(32'h88776655);
        run_frame(16'h0010, 16'd2, 8'h64, 1'b0, 1'b0, 1'b0, 1'b1, "after rst");

        for (int r = 0; r < 6; r++) begin
            logic [15:0] a, c;
            logic [7:0]  cs;
            int s;
            bit bad_cs, corr;
            a = 16'($urandom);
            c = 16'($urandom_range(0, 5));
            s = 0;
            tx_words.delete();
            for (int i = 0; i < int'(c); i++) begin
                tx_words.push_back($urandom);
                for (int k = 0; k < 4; k++) s = (s + int'(tx_words[i][8*k +: 8])) % 256;
            end
            bad_cs = ($urandom_range(0, 3) == 0);
            cs     = bad_cs ? 8'((s + 1 + $urandom_range(0, 254)) % 256) : 8'(s);
            corr   = (c != 0) && ($urandom_range(0, 4) == 0);
            run_frame(a, c, cs, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), corr,
                      !bad_cs && !corr, $sformatf("rnd%0d", r));
        end

        check("idle outputs", 64'(idle_bad), 64'd0);
        check("write wmask", 64'(wmask_bad), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
